// File: rtl/accelerator_package.sv
// Shared accelerator types: global buffer opcodes and the sequencer state encoding.
package accelerator_package;

    // Opcodes understood by the global buffer sequencer; anything above
    // I_READ_ACTIVATION is treated as an illegal instruction.
    typedef enum logic [3:0] {
        I_NOP             = 4'd0,
        I_POINTER_RESET   = 4'd1,
        I_LOAD_WEIGHT     = 4'd2,
        I_LOAD_ACTIVATION = 4'd3,
        I_LOAD_OUTPUT     = 4'd4,
        I_READ_ACTIVATION = 4'd5
    } global_buffer_instruction_t;

    // Sequencer states: idle, streaming writes, and the three-phase read loop.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_OUT  = 3'd4
    } gbseq_state_t;

    // True for the opcodes that stream src data into the buffer.
    function automatic logic isLoadOp(global_buffer_instruction_t op);
        return (op == I_LOAD_WEIGHT) || (op == I_LOAD_ACTIVATION) || (op == I_LOAD_OUTPUT);
    endfunction

endpackage

// File: rtl/global_buffer_sequencer.sv
// Global buffer sequencer: turns load/read instructions into buffer write
// bursts (from the src stream) or single-outstanding read bursts (to the dst
// stream), tracking separate weight and activation address pointers.
module global_buffer_sequencer
    import accelerator_package::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_SIZE       = 8,
    parameter int INTERFACE_DEPTH = 16,
    parameter int LEN_BITS        = 16,
    localparam int W              = INTERFACE_DEPTH * DATA_SIZE
) (
    input  logic                       clk,
    input  logic                       nrst,

    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  global_buffer_instruction_t instr_op,
    input  logic [LEN_BITS-1:0]        instr_len,

    input  logic [ADDR_WIDTH-1:0]      weight_start_addr,
    input  logic [ADDR_WIDTH-1:0]      activation_start_addr,

    input  logic                       src_valid,
    output logic                       src_ready,
    input  logic [W-1:0]               src_data,

    output logic                       buf_wr_en,
    output logic [W-1:0]               buf_wr_data,
    output logic [ADDR_WIDTH-1:0]      buf_wr_addr,
    input  logic                       buf_ready,

    output logic                       buf_rd_en,
    output logic [ADDR_WIDTH-1:0]      buf_rd_addr,
    input  logic [W-1:0]               buf_rd_data,
    input  logic                       buf_rd_data_valid,

    output logic                       dst_valid,
    input  logic                       dst_ready,
    output logic [W-1:0]               dst_data,

    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    gbseq_state_t               state_q;
    global_buffer_instruction_t op_q;
    logic [ADDR_WIDTH-1:0]      wptr_q;
    logic [ADDR_WIDTH-1:0]      aptr_q;
    logic [LEN_BITS-1:0]        cnt_q;
    logic [W-1:0]               dstData_q;
    logic                       done_q;
    logic                       err_q;

    logic [ADDR_WIDTH-1:0]      wptr_d;
    logic [ADDR_WIDTH-1:0]      aptr_d;
    logic [LEN_BITS-1:0]        cnt_d;
    logic                       lastBeat;
    logic                       writeBeat;

    // Incremented pointers wrap naturally at 2^ADDR_WIDTH.
    assign wptr_d    = wptr_q + ADDR_WIDTH'(1);
    assign aptr_d    = aptr_q + ADDR_WIDTH'(1);
    assign cnt_d     = cnt_q - LEN_BITS'(1);
    assign lastBeat  = (cnt_q == LEN_BITS'(1));
    assign writeBeat = (state_q == WRITE) && src_valid && buf_ready;

    // Sequencer FSM: instruction decode, pointer/count bookkeeping and one-cycle status pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            op_q      <= I_NOP;
            wptr_q    <= '0;
            aptr_q    <= '0;
            cnt_q     <= '0;
            dstData_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        if (instr_op == I_NOP) begin
                            done_q <= 1'b1;
                        end else if (instr_op == I_POINTER_RESET) begin
                            wptr_q <= weight_start_addr;
                            aptr_q <= activation_start_addr;
                            done_q <= 1'b1;
                        end else if (isLoadOp(instr_op) || (instr_op == I_READ_ACTIVATION)) begin
                            if (instr_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                op_q    <= instr_op;
                                cnt_q   <= instr_len;
                                state_q <= (instr_op == I_READ_ACTIVATION) ? RD_REQ : WRITE;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (writeBeat) begin
                        if (op_q == I_LOAD_WEIGHT) begin
                            wptr_q <= wptr_d;
                        end else begin
                            aptr_q <= aptr_d;
                        end
                        cnt_q <= cnt_d;
                        if (lastBeat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    aptr_q  <= aptr_d;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (buf_rd_data_valid) begin
                        dstData_q <= buf_rd_data;
                        state_q   <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    if (dst_ready) begin
                        cnt_q <= cnt_d;
                        if (lastBeat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stream and buffer handshakes are decoded straight from the current state.
    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign src_ready   = (state_q == WRITE) && buf_ready;
    assign buf_wr_en   = (state_q == WRITE) && src_valid;
    assign buf_wr_data = src_data;
    assign buf_wr_addr = (op_q == I_LOAD_WEIGHT) ? wptr_q : aptr_q;
    assign buf_rd_en   = (state_q == RD_REQ);
    assign buf_rd_addr = aptr_q;
    assign dst_valid   = (state_q == RD_OUT);
    assign dst_data    = dstData_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_global_buffer_sequencer.sv
// Directed self-checking bench for the global buffer sequencer.
module tb_global_buffer_sequencer;
    import accelerator_package::*;

    localparam int AW = 32;
    localparam int LB = 16;
    localparam int W  = 128;

    logic                       clk;
    logic                       nrst;
    logic                       instr_valid;
    logic                       instr_ready;
    global_buffer_instruction_t instr_op;
    logic [LB-1:0]              instr_len;
    logic [AW-1:0]              weight_start_addr;
    logic [AW-1:0]              activation_start_addr;
    logic                       src_valid;
    logic                       src_ready;
    logic [W-1:0]               src_data;
    logic                       buf_wr_en;
    logic [W-1:0]               buf_wr_data;
    logic [AW-1:0]              buf_wr_addr;
    logic                       buf_ready;
    logic                       buf_rd_en;
    logic [AW-1:0]              buf_rd_addr;
    logic [W-1:0]               buf_rd_data;
    logic                       buf_rd_data_valid;
    logic                       dst_valid;
    logic                       dst_ready;
    logic [W-1:0]               dst_data;
    logic                       busy;
    logic                       done;
    logic                       err;

    int errors = 0;
    int checks = 0;

    global_buffer_sequencer dut (
        .clk                   (clk),
        .nrst                  (nrst),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .instr_op              (instr_op),
        .instr_len             (instr_len),
        .weight_start_addr     (weight_start_addr),
        .activation_start_addr (activation_start_addr),
        .src_valid             (src_valid),
        .src_ready             (src_ready),
        .src_data              (src_data),
        .buf_wr_en             (buf_wr_en),
        .buf_wr_data           (buf_wr_data),
        .buf_wr_addr           (buf_wr_addr),
        .buf_ready             (buf_ready),
        .buf_rd_en             (buf_rd_en),
        .buf_rd_addr           (buf_rd_addr),
        .buf_rd_data           (buf_rd_data),
        .buf_rd_data_valid     (buf_rd_data_valid),
        .dst_valid             (dst_valid),
        .dst_ready             (dst_ready),
        .dst_data              (dst_data),
        .busy                  (busy),
        .done                  (done),
        .err                   (err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] pat(int n);
        return {4{32'hC0DE0000 + 32'(n)}};
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one instruction for a single accepting edge, returns at the next negedge.
    task automatic applyStimulus(input global_buffer_instruction_t op, input logic [LB-1:0] len);
        instr_op    = op;
        instr_len   = len;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        int beats;
        nrst = 1'b0;
        instr_valid = 1'b0;
        instr_op = I_NOP;
        instr_len = '0;
        weight_start_addr = '0;
        activation_start_addr = '0;
        src_valid = 1'b0;
        src_data = '0;
        buf_ready = 1'b0;
        buf_rd_data = '0;
        buf_rd_data_valid = 1'b0;
        dst_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_instr_ready", instr_ready, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_buf_rd_en", buf_rd_en, 0);
        checkOutput("rst_dst_valid", dst_valid, 0);
        checkOutput("rst_dst_data", dst_data, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Read-data valid while idle must not be captured
        buf_rd_data_valid = 1'b1;
        buf_rd_data = {4{32'hDEADBEEF}};
        stepCycle();
        buf_rd_data_valid = 1'b0;
        #1;
        checkOutput("idle_rdvalid_dst_data", dst_data, 0);
        checkOutput("idle_rdvalid_dst_valid", dst_valid, 0);
        checkOutput("idle_rdvalid_busy", busy, 0);

        // Pointer reset then weight load of three beats
        weight_start_addr = 32'h100;
        activation_start_addr = 32'h200;
        applyStimulus(I_POINTER_RESET, 0);
        checkOutput("ptr_reset_done", done, 1);
        checkOutput("ptr_reset_busy", busy, 0);
        applyStimulus(I_LOAD_WEIGHT, 3);
        #1;
        checkOutput("ldw_busy", busy, 1);
        checkOutput("ldw_instr_ready", instr_ready, 0);
        checkOutput("ldw_wr_en_idle_src", buf_wr_en, 0);
        checkOutput("ldw_done_early", done, 0);
        src_valid = 1'b1;
        buf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data = pat(i);
            #1;
            checkOutput($sformatf("ldw_wr_en_%0d", i), buf_wr_en, 1);
            checkOutput($sformatf("ldw_wr_addr_%0d", i), buf_wr_addr, W'(32'h100 + i));
            checkOutput($sformatf("ldw_wr_data_%0d", i), buf_wr_data, pat(i));
            checkOutput($sformatf("ldw_src_ready_%0d", i), src_ready, 1);
            checkOutput($sformatf("ldw_done_mid_%0d", i), done, 0);
            stepCycle();
        end
        src_valid = 1'b0;
        #1;
        checkOutput("ldw_done", done, 1);
        checkOutput("ldw_busy_end", busy, 0);
        checkOutput("ldw_wr_en_end", buf_wr_en, 0);
        stepCycle();
        checkOutput("ldw_done_once", done, 0);

        // Activation load with buf_ready toggling every cycle
        applyStimulus(I_LOAD_ACTIVATION, 4);
        beats = 0;
        src_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            buf_ready = (i % 2 == 0);
            src_data = pat(10 + beats);
            #1;
            if (buf_wr_en && src_ready) begin
                checkOutput($sformatf("lda_wr_addr_%0d", beats), buf_wr_addr, W'(32'h200 + beats));
                checkOutput($sformatf("lda_wr_data_%0d", beats), buf_wr_data, pat(10 + beats));
                beats++;
            end
            stepCycle();
        end
        src_valid = 1'b0;
        buf_ready = 1'b0;
        #1;
        checkOutput("lda_beat_count", beats, 4);
        checkOutput("lda_done", done, 1);
        checkOutput("lda_busy_end", busy, 0);

        // Read two activations from 0x200, latency 3, dst stalled 5 cycles
        applyStimulus(I_POINTER_RESET, 0);
        applyStimulus(I_READ_ACTIVATION, 2);
        checkOutput("rd0_rd_en", buf_rd_en, 1);
        checkOutput("rd0_rd_addr", buf_rd_addr, 32'h200);
        checkOutput("rd0_dst_valid", dst_valid, 0);
        checkOutput("rd0_busy", busy, 1);
        stepCycle();
        checkOutput("rd0_rd_en_single", buf_rd_en, 0);
        checkOutput("rd0_wait_dst_valid", dst_valid, 0);
        stepCycle();
        checkOutput("rd0_wait2_dst_valid", dst_valid, 0);
        buf_rd_data_valid = 1'b1;
        buf_rd_data = pat(100);
        stepCycle();
        buf_rd_data_valid = 1'b0;
        buf_rd_data = pat(999);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rd0_stall_valid_%0d", k), dst_valid, 1);
            checkOutput($sformatf("rd0_stall_data_%0d", k), dst_data, pat(100));
            checkOutput($sformatf("rd0_stall_rd_en_%0d", k), buf_rd_en, 0);
            stepCycle();
        end
        dst_ready = 1'b1;
        stepCycle();
        dst_ready = 1'b0;
        checkOutput("rd1_rd_en", buf_rd_en, 1);
        checkOutput("rd1_rd_addr", buf_rd_addr, 32'h201);
        checkOutput("rd1_done_early", done, 0);
        stepCycle();
        stepCycle();
        buf_rd_data_valid = 1'b1;
        buf_rd_data = pat(101);
        stepCycle();
        buf_rd_data_valid = 1'b0;
        checkOutput("rd1_dst_valid", dst_valid, 1);
        checkOutput("rd1_dst_data", dst_data, pat(101));
        dst_ready = 1'b1;
        stepCycle();
        dst_ready = 1'b0;
        checkOutput("rd_done", done, 1);
        checkOutput("rd_busy_end", busy, 0);
        checkOutput("rd_dst_valid_end", dst_valid, 0);

        // Zero-length load and illegal opcode
        applyStimulus(I_LOAD_OUTPUT, 0);
        checkOutput("ldo0_done", done, 1);
        checkOutput("ldo0_err", err, 0);
        checkOutput("ldo0_busy", busy, 0);
        applyStimulus(global_buffer_instruction_t'(4'hF), 5);
        checkOutput("badop_err", err, 1);
        checkOutput("badop_done", done, 0);
        checkOutput("badop_busy", busy, 0);
        stepCycle();
        checkOutput("badop_err_pulse", err, 0);
        src_valid = 1'b1;
        buf_ready = 1'b1;
        src_data = pat(50);
        applyStimulus(I_LOAD_ACTIVATION, 1);
        #1;
        checkOutput("aptr_kept_addr", buf_wr_addr, 32'h202);
        checkOutput("aptr_kept_wr_en", buf_wr_en, 1);
        stepCycle();
        applyStimulus(I_LOAD_WEIGHT, 1);
        #1;
        checkOutput("wptr_kept_addr", buf_wr_addr, 32'h100);
        stepCycle();
        checkOutput("wptr_kept_done", done, 1);

        // Weight pointer wrap at the top of the address space
        weight_start_addr = 32'hFFFF_FFFF;
        applyStimulus(I_POINTER_RESET, 0);
        applyStimulus(I_LOAD_WEIGHT, 2);
        #1;
        checkOutput("wrap_addr0", buf_wr_addr, 32'hFFFF_FFFF);
        stepCycle();
        checkOutput("wrap_addr1", buf_wr_addr, 32'h0);
        stepCycle();
        checkOutput("wrap_done", done, 1);

        // Asynchronous reset in the middle of a weight load
        applyStimulus(I_LOAD_WEIGHT, 3);
        #1;
        checkOutput("abort_addr0", buf_wr_addr, 32'h1);
        stepCycle();
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_instr_ready", instr_ready, 1);
        checkOutput("abort_wr_en", buf_wr_en, 0);
        checkOutput("abort_src_ready", src_ready, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_rd_en", buf_rd_en, 0);
        checkOutput("abort_dst_valid", dst_valid, 0);
        checkOutput("abort_dst_data", dst_data, 0);
        @(negedge clk);
        nrst = 1'b1;
        src_valid = 1'b0;
        stepCycle();
        checkOutput("abort_no_done", done, 0);
        src_valid = 1'b1;
        applyStimulus(I_LOAD_WEIGHT, 1);
        #1;
        checkOutput("abort_wptr_zero", buf_wr_addr, 32'h0);
        stepCycle();
        applyStimulus(I_LOAD_ACTIVATION, 1);
        #1;
        checkOutput("abort_aptr_zero", buf_wr_addr, 32'h0);
        stepCycle();
        src_valid = 1'b0;
        buf_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
